// File: rtl/fifo_rd_master_if.sv
// Handshake bundle for fifo_rd_master: the FIFO read port plus the
// downstream valid/ready stream. master = the read master, slave = the
// FIFO side together with the stream consumer.
interface fifo_rd_master_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_master.sv
// fifo_rd_master: drains a synchronous FIFO (1-cycle registered read
// latency) into a valid/ready stream. A small circular buffer absorbs the
// read latency, so the block sustains one word per cycle and never drops a
// word when m_ready falls.
// Optional feature macro: FIFO_RD_STATS_EN adds the rd_count delivery
// counter and the sticky err_underflow flag; the datapath is identical
// either way.
module fifo_rd_master #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_master_if.master     bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 err_underflow
`endif
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(BUF_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);

    logic [CW-1:0]         buf_count;
    logic                  inflight;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [FIFO_WIDTH-1:0] buf_mem [BUF_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [CW:0]           occ_after;

    // Handshake decode and read request. A read is issued only if the word
    // it returns is guaranteed a slot, counting the one already in flight
    // and the slot freed by this cycle's pop.
    always_comb begin
        pop       = (buf_count != '0) & bus.m_ready;
        push      = inflight & ~bus.fifo_underflow;
        occ_after = {1'b0, buf_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        rd_en     = ~rst & ~bus.fifo_empty & (occ_after < DEPTH_W);
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (buf_count != '0);
    assign bus.m_data     = buf_mem[rd_idx];

    // Buffer state: capture the returning FIFO word, advance indices, track
    // occupancy. Reset clears the storage so m_data reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_count <= '0;
            inflight  <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= rd_en;
            if (push) begin
                buf_mem[wr_idx] <= bus.fifo_data_out;
                wr_idx          <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
            end
            if (pop) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    // Delivery counter (wraps naturally) and sticky underflow flag; a word
    // lost to underflow is reported here since the datapath silently drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            if (inflight & bus.fifo_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
